urv_im_wb_bridge: RTL

- Upstream neighbour of the uRV fetch stage; the fetch stage is the consumer of this block's instruction port.
- Converts the fetch stage's registered instruction-memory port (address/read in, data/valid out one cycle later) into a Wishbone B4 pipelined read master.
- Holds a 2-entry tagged instruction buffer: repeated addresses hit without bus traffic, and the sequential successor can be prefetched.
- Stale responses after a branch are harmless: every entry carries its own address tag.

---
 rtl/urv_defs.sv | 20 ++
 rtl/urv_im_buf2.sv | 89 ++++++++
 rtl/urv_im_wb_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/urv_defs.sv
// Shared definitions for the uRV instruction-memory Wishbone bridge:
// FSM encoding, error-fill word and word-alignment helpers.
package urv_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } fsm_state_e;

    // An all-zero word decodes as an illegal instruction in the fetch stage.
    localparam logic [31:0] ERR_FILL_DATA = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_STRIDE   = 32'h0000_0004;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/urv_im_buf2.sv
// Two-entry tagged instruction buffer: lookup, prefetch presence query,
// and a single write port that never evicts the entry matching the lookup address.
module urv_im_buf2
    import urv_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] lkp_addr_i,
    output logic        lkp_hit_o,
    output logic [31:0] lkp_data_o,
    input  logic [31:0] pf_addr_i,
    output logic        pf_present_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i
);

    logic [1:0]  valid_q, valid_d;
    logic [31:0] tag_q  [2];
    logic [31:0] tag_d  [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic        lru_q, lru_d;
    logic [1:0]  lkp_match_s;
    logic [1:0]  pf_match_s;
    logic        victim_s;

    // Tag compare for the current fetch address and the prefetch candidate.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lkp_match_s[i] = valid_q[i] && (tag_q[i] == lkp_addr_i);
            pf_match_s[i]  = valid_q[i] && (tag_q[i] == pf_addr_i);
        end
        lkp_hit_o    = |lkp_match_s;
        pf_present_o = |pf_match_s;
        if (lkp_match_s[0]) begin
            lkp_data_o = data_q[0];
        end else if (lkp_match_s[1]) begin
            lkp_data_o = data_q[1];
        end else begin
            lkp_data_o = 32'h0000_0000;
        end
    end

    // Victim: keep whatever serves the fetch stage now, else the older write.
    always_comb begin
        if (lkp_match_s[0]) begin
            victim_s = 1'b1;
        end else if (lkp_match_s[1]) begin
            victim_s = 1'b0;
        end else begin
            victim_s = lru_q;
        end
    end

    // Next-state of the array on a fill.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        lru_d   = lru_q;
        if (wr_en_i) begin
            valid_d[victim_s] = 1'b1;
            tag_d[victim_s]   = wr_addr_i;
            data_d[victim_s]  = wr_data_i;
            lru_d             = ~victim_s;
        end else begin
            lru_d = lru_q;
        end
    end

    // Array state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 2'b00;
            lru_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                tag_q[i]  <= 32'h0000_0000;
                data_q[i] <= 32'h0000_0000;
            end
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/urv_im_wb_bridge.sv
// Fetch-port to Wishbone B4 pipelined read bridge with a 2-entry tagged
// buffer and optional sequential prefetch; one transfer outstanding at most.
module urv_im_wb_bridge
    import urv_defs::*;
#(
    parameter int g_prefetch = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    input  logic        im_rd_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam logic PREFETCH_EN = (g_prefetch != 0);

    fsm_state_e  state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] fill_addr_q, fill_addr_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        hit_s;
    logic        pf_present_s;
    logic [31:0] pf_addr_s;
    logic        fill_we_s;
    logic [31:0] fill_data_s;

    assign pf_addr_s = req_addr_q + WORD_STRIDE;

    urv_im_buf2 u_buf (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .lkp_addr_i   (req_addr_q),
        .lkp_hit_o    (hit_s),
        .lkp_data_o   (im_data_o),
        .pf_addr_i    (pf_addr_s),
        .pf_present_o (pf_present_s),
        .wr_en_i      (fill_we_s),
        .wr_addr_i    (fill_addr_q),
        .wr_data_i    (fill_data_s)
    );

    // Fetch address capture.
    always_comb begin
        if (im_rd_i) begin
            req_addr_d = word_align(im_addr_i);
        end else begin
            req_addr_d = req_addr_q;
        end
    end

    // Bus FSM: demand misses first, then the sequential successor.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_we_s   = 1'b0;
        fill_data_s = wb_dat_i;
        case (state_q)
            ST_IDLE: begin
                if (!hit_s) begin
                    state_d     = ST_REQ;
                    fill_addr_d = req_addr_q;
                end else if (PREFETCH_EN && !pf_present_s) begin
                    state_d     = ST_REQ;
                    fill_addr_d = pf_addr_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!wb_stall_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // The fill lands under its own tag even if the fetch address moved on.
                if (wb_ack_i || wb_err_i) begin
                    fill_we_s = 1'b1;
                    state_d   = ST_IDLE;
                    if (wb_ack_i) begin
                        fill_data_s = wb_dat_i;
                    end else begin
                        fill_data_s = ERR_FILL_DATA;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cyc_d = (state_d != ST_IDLE);
        stb_d = (state_d == ST_REQ);
    end

    // Bridge state and Wishbone output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= 32'h0000_0000;
            fill_addr_q <= 32'h0000_0000;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            fill_addr_q <= fill_addr_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
        end
    end

    assign im_valid_o = hit_s;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_adr_o   = fill_addr_q;
    assign wb_sel_o   = 4'hF;
    assign wb_we_o    = 1'b0;

endmodule
